// File: rtl/regfile_rename_pkg.sv
// Shared widths and helpers for the renaming register file.
package regfile_rename_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int ROBENTRY_W = 5;
   localparam int NRD        = 2;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG   = '0;
   localparam logic [ROBENTRY_W-1:0] ENTRY_NULL = '0;

   function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] a);
      return a == ZERO_REG;
   endfunction
endpackage

// File: rtl/regfile_rename_if.sv
// Issue/rename/commit bus of the register file; flush exists only with REGFILE_FLUSH_EN.
interface regfile_rename_if
   import regfile_rename_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = ROBENTRY_W
);
   logic [REG_ADDR_W-1:0] rs1_addr, rs2_addr;
   logic                  rs1_busy, rs2_busy;
   logic [TAG_W-1:0]      rs1_tag,  rs2_tag;
   logic [XLEN-1:0]       rs1_value, rs2_value;
   logic                  rename_en;
   logic [REG_ADDR_W-1:0] rename_rd;
   logic [TAG_W-1:0]      rename_tag;
   logic                  commit_sgn;
   logic [TAG_W-1:0]      commit_entry;
   logic [REG_ADDR_W:0]   commit_des;
   logic [XLEN-1:0]       commit_result;
`ifdef REGFILE_FLUSH_EN
   logic                  flush;

   modport master (
      output rs1_addr, rs2_addr, rename_en, rename_rd, rename_tag,
             commit_sgn, commit_entry, commit_des, commit_result, flush,
      input  rs1_busy, rs1_tag, rs1_value, rs2_busy, rs2_tag, rs2_value
   );
   modport slave (
      input  rs1_addr, rs2_addr, rename_en, rename_rd, rename_tag,
             commit_sgn, commit_entry, commit_des, commit_result, flush,
      output rs1_busy, rs1_tag, rs1_value, rs2_busy, rs2_tag, rs2_value
   );
`else
   modport master (
      output rs1_addr, rs2_addr, rename_en, rename_rd, rename_tag,
             commit_sgn, commit_entry, commit_des, commit_result,
      input  rs1_busy, rs1_tag, rs1_value, rs2_busy, rs2_tag, rs2_value
   );
   modport slave (
      input  rs1_addr, rs2_addr, rename_en, rename_rd, rename_tag,
             commit_sgn, commit_entry, commit_des, commit_result,
      output rs1_busy, rs1_tag, rs1_value, rs2_busy, rs2_tag, rs2_value
   );
`endif
endinterface

// File: rtl/regfile_rename_read_port.sv
// One source-operand read port: x0 forcing and same-cycle commit bypass.
module regfile_read_port
   import regfile_rename_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = ROBENTRY_W
) (
   input  logic [REG_ADDR_W-1:0] addr,
   input  logic                  st_busy,
   input  logic [TAG_W-1:0]      st_tag,
   input  logic [XLEN-1:0]       st_value,
   input  logic                  commit_vld,
   input  logic [REG_ADDR_W-1:0] commit_idx,
   input  logic [TAG_W-1:0]      commit_entry,
   input  logic [XLEN-1:0]       commit_result,
   output logic                  busy,
   output logic [TAG_W-1:0]      tag,
   output logic [XLEN-1:0]       value
);
   always_comb begin
      busy  = st_busy;
      tag   = st_tag;
      value = st_value;
      if (is_zero_reg(addr)) begin
         busy  = 1'b0;
         tag   = '0;
         value = '0;
      end else if (commit_vld && commit_idx == addr && commit_entry == st_tag && st_busy) begin
         // the producer is retiring right now: hand over its result directly
         busy  = 1'b0;
         value = commit_result;
      end
   end
endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with rename tags behind the ROB commit port.
// Optional REGFILE_FLUSH_EN adds a flush input that clears all busy bits.
module regfile_rename
   import regfile_rename_pkg::*;
#(
   parameter int NREG  = 32,
   parameter int XLEN  = 32,
   parameter int TAG_W = ROBENTRY_W
) (
   input  logic clk,
   input  logic rst,
   input  logic rdy,
   regfile_rename_if.slave rf
);
   logic [NREG-1:0][XLEN-1:0]  value_q;
   logic [NREG-1:0]            busy_q;
   logic [NREG-1:0][TAG_W-1:0] tag_q;

   logic                  flush_w;
   logic                  commit_vld;
   logic [REG_ADDR_W-1:0] commit_idx;

`ifdef REGFILE_FLUSH_EN
   assign flush_w = rf.flush;
`else
   assign flush_w = 1'b0;
`endif

   // commit_des[5] set means no register destination
   assign commit_vld = rf.commit_sgn && !rf.commit_des[REG_ADDR_W];
   assign commit_idx = rf.commit_des[REG_ADDR_W-1:0];

   logic [NRD-1:0][REG_ADDR_W-1:0] rd_addr;
   logic [NRD-1:0]                 rd_busy;
   logic [NRD-1:0][TAG_W-1:0]      rd_tag;
   logic [NRD-1:0][XLEN-1:0]       rd_value;

   assign rd_addr[0]   = rf.rs1_addr;
   assign rd_addr[1]   = rf.rs2_addr;
   assign rf.rs1_busy  = rd_busy[0];
   assign rf.rs1_tag   = rd_tag[0];
   assign rf.rs1_value = rd_value[0];
   assign rf.rs2_busy  = rd_busy[1];
   assign rf.rs2_tag   = rd_tag[1];
   assign rf.rs2_value = rd_value[1];

   for (genvar i = 0; i < NRD; i++) begin : g_rp
      regfile_read_port #(.XLEN(XLEN), .TAG_W(TAG_W)) u_rp (
         .addr          (rd_addr[i]),
         .st_busy       (busy_q[rd_addr[i]]),
         .st_tag        (tag_q[rd_addr[i]]),
         .st_value      (value_q[rd_addr[i]]),
         .commit_vld    (commit_vld),
         .commit_idx    (commit_idx),
         .commit_entry  (rf.commit_entry),
         .commit_result (rf.commit_result),
         .busy          (rd_busy[i]),
         .tag           (rd_tag[i]),
         .value         (rd_value[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_q <= '0;
         busy_q  <= '0;
         tag_q   <= '0;
      end else if (rdy) begin
         if (flush_w)
            busy_q <= '0;
         if (commit_vld && !is_zero_reg(commit_idx)) begin
            value_q[commit_idx] <= rf.commit_result;
            if (busy_q[commit_idx] && tag_q[commit_idx] == rf.commit_entry)
               busy_q[commit_idx] <= 1'b0;
         end
         // rename is last so it owns busy/tag when it collides with a commit
         if (rf.rename_en && !is_zero_reg(rf.rename_rd) && !flush_w) begin
            busy_q[rf.rename_rd] <= 1'b1;
            tag_q[rf.rename_rd]  <= rf.rename_tag;
         end
      end
   end
endmodule
